bias_replay_fifo: RTL and testbench
===================================

# bias_replay_fifo

Parametrised bias buffer for the convolution datapath, successor to the single-mode bias FIFO. It holds up to DEPTH bias words. They are preloaded by address and committed with an explicit length. It serves them in one of two modes: consume (classic FIFO; entries leave on pop) or replay (non-destructive circular read over the committed entries, so one bias set can be streamed once per output tile). It sits between the weight/bias loader and the accumulator-bias adder.

## Interface
- DATA_WIDTH, 32, bias word width (Q-format is opaque to this block)
- DEPTH, 16, entry count; power of two, ≥ 2
- ADDR_WIDTH, $clog2(DEPTH), derived; not overridden
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- push  in  1  write data_in at tail (consume mode only)
- data_in  in  DATA_WIDTH  push data
- pop  in  1  read request
- data_out  out  DATA_WIDTH  registered read data
- out_valid  out  1  one-cycle pulse; data_out is new this cycle
- last  out  1  with out_valid in replay mode; the emitted entry is index count-1
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  ADDR_WIDTH+1  committed/live entry count
- preload_en  in  1  write preload_data to preload_addr
- preload_addr  in  ADDR_WIDTH  preload address
- preload_data  in  DATA_WIDTH  preload data
- preload_done  in  1  commit pulse
- preload_len  in  ADDR_WIDTH+1  entries valid after commit; sampled with preload_done
- replay_en  in  1  mode for the committed set; sampled with preload_done
- ovf  out  1  sticky: push rejected
- udf  out  1  sticky: pop rejected

## Operation
- Reset values: rd_ptr=0, wr_ptr=0, count=0, mode=consume, data_out=0, out_valid=0, last=0, ovf=0, udf=0. Memory is not reset.
- Preload: while preload_en=1, mem[preload_addr] ← preload_data. push/pop in the same cycle are dropped silently: no state change, no flag.
- Commit (preload_done=1, rst=0):
  - len = min(preload_len, DEPTH); rd_ptr ← 0; wr_ptr ← len mod DEPTH; count ← len.
  - mode ← replay_en; ovf, udf ← 0.
  - push/pop that cycle are dropped.
  - A preload_en write in the same cycle still lands.
- Consume mode:
  - pop_ok = pop & !empty. On pop_ok: data_out ← mem[rd_ptr], rd_ptr+1 (wraps at DEPTH), count−1. The entry is not cleared.
  - push_ok = push & (!full | pop_ok). On push_ok: mem[wr_ptr] ← data_in, wr_ptr+1 (wraps at DEPTH), count+1.
  - Push and pop together: count is unchanged. When full, both are accepted. When empty, the push is accepted and the pop is rejected; there is no bypass.
- Replay mode:
  - pop_ok = pop & (count≠0). On pop_ok: data_out ← mem[rd_ptr]; rd_ptr ← (rd_ptr == count−1) ? 0 : rd_ptr+1.
  - count is never changed by pop. last ← (rd_ptr == count−1).
  - Every push is rejected.
- Error flags:
  - ovf ← 1 on a rejected push (push & !push_ok), except in preload/commit cycles.
  - udf ← 1 on pop & !pop_ok, except in preload/commit cycles.
  - Both clear only on rst or commit.
- Arithmetic: pointers are ADDR_WIDTH bits with natural wrap. count is ADDR_WIDTH+1 bits and never exceeds DEPTH or goes below 0.

## Timing
- pop_ok at edge N → data_out, out_valid=1 (and last, if applicable) visible after edge N, for one cycle. Between pops, out_valid=0, last=0, and data_out holds its value.
- Push at edge N → entry is poppable from edge N+1.
- Commit at edge N → first replay/consume pop is legal at edge N+1.
- full, empty, count are combinational from registered state; they reflect an edge's effect right after it.
- Priority per edge: rst > preload_done > preload_en gating > push/pop.
- rst mid-preload: pointers, count, mode and flags reset. A concurrent preload_en memory write still completes. A later commit is required before the entries are visible.
- Back-to-back pops every cycle give one output per cycle in both modes. No bubbles at replay wrap.

## Test plan
- Reset then pop → out_valid stays 0, udf=1, empty=1, count=0. Commit with len 0 → udf clears.
- Preload addr0..3 = 10,20,30,40; commit len=4, replay_en=0; 4 pops → data_out 10,20,30,40 on consecutive cycles; empty=1. A 5th pop → udf=1.
- Same preload, commit len=3, replay_en=1; 7 consecutive pops → 10,20,30,10,20,30,10. last=1 on the 3rd and 6th outputs only. count=3 throughout. A push → ovf=1 and count stays 3.
- Consume mode: fill with 4 pushes (1,2,3,4), full=1. Push 5 together with pop → out 1, count=4. Drain → 2,3,4,5. wr_ptr wrap verified.
- Push and pop together while preload_en=1 → no change to count/pointers, ovf=udf=0. Then push+pop when empty → push accepted (count=1), udf=1.
- Commit with preload_len=DEPTH+3 → count=DEPTH, full=1. Assert rst mid-replay → out_valid=0, count=0, mode consume. Memory contents are readable again after re-commit.

Source files
------------

// File: rtl/bias_replay_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bias_replay_fifo
//  Description : Bias word buffer for the convolution datapath. Entries are
//                preloaded by address and committed with an explicit length,
//                then served either as a classic FIFO (consume) or as a
//                non-destructive circular stream over the committed set
//                (replay), so one bias set can feed every output tile.
//  Revision    : 1.0 - initial release
// ============================================================================
module bias_replay_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  last,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  preload_en,
    input  logic [ADDR_WIDTH-1:0] preload_addr,
    input  logic [DATA_WIDTH-1:0] preload_data,
    input  logic                  preload_done,
    input  logic [ADDR_WIDTH:0]   preload_len,
    input  logic                  replay_en,
    output logic                  ovf,
    output logic                  udf
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic                c_MODE_CONSUME = 1'b0;
    localparam logic                c_MODE_REPLAY  = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,     count_d;
    logic                  mode_q,      mode_d;
    logic [DATA_WIDTH-1:0] data_out_q,  data_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  last_q,      last_d;
    logic                  ovf_q,       ovf_d;
    logic                  udf_q,       udf_d;

    logic                  w_gate;
    logic                  w_full;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_at_end;
    logic [ADDR_WIDTH:0]   w_commit_len;

    assign w_full  = (count_q == c_DEPTH_CNT);

    // Preload and commit cycles own the buffer; push/pop are silently dropped.
    assign w_gate    = preload_en | preload_done;
    assign w_pop_ok  = pop & (count_q != '0) & ~w_gate;
    assign w_push_ok = push & ~w_gate & (mode_q == c_MODE_CONSUME) & (~w_full | w_pop_ok);

    // Replay wraps after the last committed entry rather than at DEPTH.
    assign w_at_end     = ({1'b0, rd_ptr_q} == (count_q - 1'b1));
    assign w_commit_len = (preload_len > c_DEPTH_CNT) ? c_DEPTH_CNT : preload_len;

    // Memory write port: preload has priority; pushes are blocked during reset.
    always_ff @(posedge clk) begin
        if (preload_en) begin
            mem[preload_addr] <= preload_data;
        end else if (w_push_ok && !rst) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    // Next-state logic for pointers, occupancy, mode, read data and flags.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        mode_d      = mode_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        last_d      = 1'b0;
        ovf_d       = ovf_q;
        udf_d       = udf_q;

        if (preload_done) begin
            rd_ptr_d = '0;
            wr_ptr_d = w_commit_len[ADDR_WIDTH-1:0];
            count_d  = w_commit_len;
            mode_d   = replay_en ? c_MODE_REPLAY : c_MODE_CONSUME;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else if (!preload_en) begin
            if (w_pop_ok) begin
                data_out_d  = mem[rd_ptr_q];
                out_valid_d = 1'b1;
                if (mode_q == c_MODE_REPLAY) begin
                    last_d   = w_at_end;
                    rd_ptr_d = w_at_end ? '0 : rd_ptr_q + 1'b1;
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            if (w_push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            // Only consume-mode pops drain the buffer.
            case ({w_push_ok, w_pop_ok & (mode_q == c_MODE_CONSUME)})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (push & ~w_push_ok);
            udf_d = udf_q | (pop & ~w_pop_ok);
        end
    end

    // State register with synchronous reset; memory contents are not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            mode_q      <= c_MODE_CONSUME;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign last      = last_q;
    assign count     = count_q;
    assign full      = w_full;
    assign empty     = (count_q == '0);
    assign ovf       = ovf_q;
    assign udf       = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_bias_replay_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bias_replay_fifo
//  Description : Self-checking bench for bias_replay_fifo: a table of
//                directed cycles with hand-derived expectations, a short
//                replay corner sequence, and randomized traffic compared
//                against a queue-style reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_replay_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int PW    = DW + AW + 7;

    logic          clk = 1'b0;
    logic          rst, push, pop, preload_en, preload_done, replay_en;
    logic [DW-1:0] data_in, preload_data, data_out;
    logic [AW-1:0] preload_addr;
    logic [AW:0]   preload_len, count;
    logic          out_valid, last, full, empty, ovf, udf;

    always #5 clk = ~clk;

    bias_replay_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .out_valid(out_valid), .last(last), .full(full),
        .empty(empty), .count(count), .preload_en(preload_en),
        .preload_addr(preload_addr), .preload_data(preload_data),
        .preload_done(preload_done), .preload_len(preload_len),
        .replay_en(replay_en), .ovf(ovf), .udf(udf)
    );

    typedef struct {
        bit            rst;
        bit            pe;
        bit [AW-1:0]   pa;
        bit [DW-1:0]   pd;
        bit            pdn;
        bit [AW:0]     pl;
        bit            rep;
        bit            pu;
        bit [DW-1:0]   di;
        bit            po;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          v;
        bit          l;
        bit          o;
        bit          u;
        int          c;
        bit [DW-1:0] d;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: a circular store viewed as head + occupancy.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_head, m_cnt, m_ridx;
    bit            m_replay;
    logic [DW-1:0] m_dout;
    bit            m_valid, m_last, m_ovf, m_udf;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t s_pop();
        stim_t s = idle();
        s.po = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_push(input bit [DW-1:0] d);
        stim_t s = idle();
        s.pu = 1'b1;
        s.di = d;
        return s;
    endfunction

    function automatic stim_t s_pl(input bit [AW-1:0] a, input bit [DW-1:0] d);
        stim_t s = idle();
        s.pe = 1'b1;
        s.pa = a;
        s.pd = d;
        return s;
    endfunction

    function automatic stim_t s_cm(input bit [AW:0] len, input bit rep);
        stim_t s = idle();
        s.pdn = 1'b1;
        s.pl  = len;
        s.rep = rep;
        return s;
    endfunction

    task automatic add(input stim_t s, input bit v, input bit l, input bit o,
                       input bit u, input int c, input bit [DW-1:0] d);
        vec_t x;
        x.s = s; x.v = v; x.l = l; x.o = o; x.u = u; x.c = c; x.d = d;
        vecs.push_back(x);
    endtask

    task automatic model_step();
        bit pop_ok, push_ok;
        if (preload_en) m_mem[preload_addr] = preload_data;
        if (rst) begin
            m_head = 0; m_cnt = 0; m_ridx = 0; m_replay = 1'b0;
            m_dout = '0; m_valid = 1'b0; m_last = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (preload_done) begin
            m_head = 0; m_ridx = 0;
            m_cnt = (int'(preload_len) > DEPTH) ? DEPTH : int'(preload_len);
            m_replay = replay_en;
            m_valid = 1'b0; m_last = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (preload_en) begin
            m_valid = 1'b0; m_last = 1'b0;
        end else if (!m_replay) begin
            pop_ok  = pop && (m_cnt > 0);
            push_ok = push && ((m_cnt < DEPTH) || pop_ok);
            if (pop_ok) m_dout = m_mem[m_head];
            if (push_ok) m_mem[(m_head + m_cnt) % DEPTH] = data_in;
            if (pop_ok) begin m_head = (m_head + 1) % DEPTH; m_cnt--; end
            if (push_ok) m_cnt++;
            m_valid = pop_ok; m_last = 1'b0;
            m_ovf = m_ovf | (push && !push_ok);
            m_udf = m_udf | (pop && !pop_ok);
        end else begin
            pop_ok = pop && (m_cnt > 0);
            m_last = 1'b0;
            if (pop_ok) begin
                m_dout = m_mem[m_ridx];
                m_last = (m_ridx == m_cnt - 1);
                m_ridx = m_last ? 0 : m_ridx + 1;
            end
            m_valid = pop_ok;
            m_ovf = m_ovf | push;
            m_udf = m_udf | (pop && !pop_ok);
        end
    endtask

    task automatic cycle(input stim_t s);
        rst = s.rst; preload_en = s.pe; preload_addr = s.pa; preload_data = s.pd;
        preload_done = s.pdn; preload_len = s.pl; replay_en = s.rep;
        push = s.pu; data_in = s.di; pop = s.po;
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [PW-1:0] actual();
        return {out_valid, last, ovf, udf, full, empty, count, data_out};
    endfunction

    function automatic logic [PW-1:0] pack_exp(input bit v, input bit l, input bit o,
                                               input bit u, input int c, input bit [DW-1:0] d);
        logic [AW:0] cc = c[AW:0];
        return {v, l, o, u, (c == DEPTH), (c == 0), cc, d};
    endfunction

    task automatic compare(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {vld,last,ovf,udf,full,empty,count,data}=%b %b %b %b %b %b %0d %h, wanted %b %b %b %b %b %b %0d %h",
                     name, act[PW-1], act[PW-2], act[PW-3], act[PW-4], act[PW-5], act[PW-6],
                     act[DW+AW:DW], act[DW-1:0],
                     exp[PW-1], exp[PW-2], exp[PW-3], exp[PW-4], exp[PW-5], exp[PW-6],
                     exp[DW+AW:DW], exp[DW-1:0]);
        end
    endtask

    initial begin
        stim_t s;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_head = 0; m_cnt = 0; m_ridx = 0; m_replay = 1'b0;
        m_dout = '0; m_valid = 1'b0; m_last = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

        // ---------------- directed table ----------------
        s = idle(); s.rst = 1'b1;
        add(s, 0,0,0,0, 0, 0);
        add(s, 0,0,0,0, 0, 0);
        add(s_pop(),       0,0,0,1, 0, 0);
        add(s_cm(0, 0),    0,0,0,0, 0, 0);
        add(s_pl(0, 10),   0,0,0,0, 0, 0);
        add(s_pl(1, 20),   0,0,0,0, 0, 0);
        add(s_pl(2, 30),   0,0,0,0, 0, 0);
        add(s_pl(3, 40),   0,0,0,0, 0, 0);
        add(s_cm(4, 0),    0,0,0,0, 4, 0);
        add(s_pop(),       1,0,0,0, 3, 10);
        add(s_pop(),       1,0,0,0, 2, 20);
        add(s_pop(),       1,0,0,0, 1, 30);
        add(s_pop(),       1,0,0,0, 0, 40);
        add(s_pop(),       0,0,0,1, 0, 40);
        add(s_cm(3, 1),    0,0,0,0, 3, 40);
        add(s_pop(),       1,0,0,0, 3, 10);
        add(s_pop(),       1,0,0,0, 3, 20);
        add(s_pop(),       1,1,0,0, 3, 30);
        add(s_pop(),       1,0,0,0, 3, 10);
        add(s_pop(),       1,0,0,0, 3, 20);
        add(s_pop(),       1,1,0,0, 3, 30);
        add(s_pop(),       1,0,0,0, 3, 10);
        add(s_push(99),    0,0,1,0, 3, 10);
        add(idle(),        0,0,1,0, 3, 10);
        add(s_cm(0, 0),    0,0,0,0, 0, 10);
        add(s_push(1),     0,0,0,0, 1, 10);
        add(s_push(2),     0,0,0,0, 2, 10);
        add(s_push(3),     0,0,0,0, 3, 10);
        add(s_push(4),     0,0,0,0, 4, 10);
        s = s_push(5); s.po = 1'b1;
        add(s,             1,0,0,0, 4, 1);
        add(s_pop(),       1,0,0,0, 3, 2);
        add(s_pop(),       1,0,0,0, 2, 3);
        add(s_pop(),       1,0,0,0, 1, 4);
        add(s_pop(),       1,0,0,0, 0, 5);
        s = s_pl(0, 55); s.pu = 1'b1; s.di = 7; s.po = 1'b1;
        add(s,             0,0,0,0, 0, 5);
        s = s_push(8); s.po = 1'b1;
        add(s,             0,0,0,1, 1, 5);
        add(s_pop(),       1,0,0,1, 0, 8);
        add(s_cm(7, 1),    0,0,0,0, 4, 8);
        add(s_pop(),       1,0,0,0, 4, 55);
        add(s_pop(),       1,0,0,0, 4, 8);
        s = s_pop(); s.rst = 1'b1;
        add(s,             0,0,0,0, 0, 0);
        add(s_push(9),     0,0,0,0, 1, 0);
        add(s_cm(4, 1),    0,0,0,0, 4, 0);
        add(s_pop(),       1,0,0,0, 4, 9);
        add(s_pop(),       1,0,0,0, 4, 8);
        add(s_pop(),       1,0,0,0, 4, 3);
        add(s_pop(),       1,1,0,0, 4, 4);
        s = s_pl(2, 77); s.rst = 1'b1;
        add(s,             0,0,0,0, 0, 0);
        add(s_cm(4, 0),    0,0,0,0, 4, 0);
        add(s_pop(),       1,0,0,0, 3, 9);
        add(s_pop(),       1,0,0,0, 2, 8);
        add(s_pop(),       1,0,0,0, 1, 77);

        foreach (vecs[i]) begin
            cycle(vecs[i].s);
            compare($sformatf("vec%0d", i), actual(),
                    pack_exp(vecs[i].v, vecs[i].l, vecs[i].o, vecs[i].u, vecs[i].c, vecs[i].d));
        end

        // ---------------- single-entry replay: preload lands in commit cycle ----------------
        s = s_pl(0, 32'hAA); s.pdn = 1'b1; s.pl = 1; s.rep = 1'b1;
        cycle(s);
        compare("len1_commit", actual(), pack_exp(0,0,0,0, 1, 77));
        for (int k = 0; k < 3; k++) begin
            cycle(s_pop());
            compare($sformatf("len1_pop%0d", k), actual(), pack_exp(1,1,0,0, 1, 32'hAA));
        end
        cycle(idle());
        compare("len1_idle", actual(), pack_exp(0,0,0,0, 1, 32'hAA));

        // ---------------- randomized traffic vs reference model ----------------
        for (int n = 0; n < 1500; n++) begin
            s = idle();
            s.rst = ($urandom_range(0, 99) == 0);
            s.pdn = ($urandom_range(0, 19) == 0);
            s.pe  = ($urandom_range(0, 9) == 0);
            s.pa  = AW'($urandom_range(0, DEPTH - 1));
            s.pd  = $urandom;
            s.pl  = (AW + 1)'($urandom_range(0, 7));
            s.rep = $urandom_range(0, 1) == 1;
            s.pu  = $urandom_range(0, 2) != 0;
            s.di  = $urandom;
            s.po  = $urandom_range(0, 2) != 0;
            cycle(s);
            compare($sformatf("rand%0d", n), actual(),
                    pack_exp(m_valid, m_last, m_ovf, m_udf, m_cnt, m_dout));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
